// File: rtl/traffic_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : traffic_fsm
// Description : Four-way intersection light controller. The controller cycles
//               ALL_RED -> GREEN/EXT_GREEN -> YELLOW for one direction at a
//               time. Directions are picked by a rotating pointer that skips
//               directions with no demand. State transitions are triggered by
//               an external timer expiry pulse. Each state uses the state
//               code to select its own duration. An emergency input forces
//               and holds all-red.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               expired    - timer expiry pulse for the current state
//               demand     - [d] vehicle present on direction d
//               congestion - [d] direction d congested (extended green)
//               emergency  - level, forces and holds all-red
//               state      - current state code, drives the timer
//               lights     - [3d+2:3d] = {red, yellow, green} for direction d
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_fsm #(
    parameter int FIRST_DIR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        expired,
    input  logic [3:0]  demand,
    input  logic [3:0]  congestion,
    input  logic        emergency,
    output logic [3:0]  state,
    output logic [11:0] lights
);

    typedef enum logic [3:0] {
        ST_ALL_RED = 4'd0,
        ST_GREEN_0 = 4'd1,  ST_EXT_0 = 4'd2,  ST_YEL_0 = 4'd3,
        ST_GREEN_1 = 4'd4,  ST_EXT_1 = 4'd5,  ST_YEL_1 = 4'd6,
        ST_GREEN_2 = 4'd7,  ST_EXT_2 = 4'd8,  ST_YEL_2 = 4'd9,
        ST_GREEN_3 = 4'd10, ST_EXT_3 = 4'd11, ST_YEL_3 = 4'd12
    } state_t;

    localparam logic [1:0]  C_FIRST_DIR  = 2'(FIRST_DIR);
    localparam logic [11:0] C_ALL_RED_LT = 12'b100_100_100_100;

    // Phase offsets within a direction's group of three codes.
    localparam logic [3:0] C_PH_GREEN = 4'd1;
    localparam logic [3:0] C_PH_EXT   = 4'd2;
    localparam logic [3:0] C_PH_YEL   = 4'd3;

    // Build the state code for direction d and phase offset ph (1..3).
    function automatic state_t f_enc(input logic [1:0] d, input logic [3:0] ph);
        return state_t'(({2'b00, d} * 4'd3) + ph);
    endfunction

    // Build the lamp pattern shown while in state s.
    function automatic logic [11:0] f_lights(input state_t s);
        logic [11:0] lt;
        lt = C_ALL_RED_LT;
        for (int d = 0; d < 4; d++) begin
            if (s == f_enc(2'(d), C_PH_GREEN) || s == f_enc(2'(d), C_PH_EXT)) begin
                lt[3*d +: 3] = 3'b001;
            end else if (s == f_enc(2'(d), C_PH_YEL)) begin
                lt[3*d +: 3] = 3'b010;
            end
        end
        return lt;
    endfunction

    state_t      r_state;
    logic [11:0] r_lights;
    logic [1:0]  r_ptr;
    logic        r_guard;

    state_t      w_next_state;
    logic [1:0]  w_next_ptr;
    logic        w_next_guard;
    logic        w_is_green;
    logic        w_is_ext;
    logic        w_is_yel;
    logic [1:0]  w_cur_dir;
    logic [1:0]  w_sel;
    logic        w_valid;

    // Decode the current state into (phase, direction).
    always_comb begin
        w_is_green = 1'b0;
        w_is_ext   = 1'b0;
        w_is_yel   = 1'b0;
        w_cur_dir  = 2'd0;
        for (int d = 0; d < 4; d++) begin
            if (r_state == f_enc(2'(d), C_PH_GREEN)) begin
                w_is_green = 1'b1;
                w_cur_dir  = 2'(d);
            end
            if (r_state == f_enc(2'(d), C_PH_EXT)) begin
                w_is_ext  = 1'b1;
                w_cur_dir = 2'(d);
            end
            if (r_state == f_enc(2'(d), C_PH_YEL)) begin
                w_is_yel  = 1'b1;
                w_cur_dir = 2'(d);
            end
        end
    end

    // Rotating search from ptr for the first direction with demand. The loop
    // runs from the farthest offset down so the closest match wins. When
    // no direction has demand, ptr itself is served.
    always_comb begin
        logic [1:0] w_idx;
        w_sel = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (demand[w_idx]) begin
                w_sel = w_idx;
            end
        end
    end

    // Expiry in the first cycle of a state is ignored. This stops a pulse
    // that was left over from the previous state's timer from skipping a phase.
    assign w_valid = expired && !r_guard;

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        if (emergency) begin
            w_next_state = ST_ALL_RED;
            // Put the interrupted direction first so it is served again.
            if (w_is_green || w_is_ext || w_is_yel) begin
                w_next_ptr = w_cur_dir;
            end
        end else if (r_state == ST_ALL_RED) begin
            if (w_valid) begin
                w_next_state = congestion[w_sel] ? f_enc(w_sel, C_PH_EXT)
                                                 : f_enc(w_sel, C_PH_GREEN);
            end
        end else if (w_is_green || w_is_ext) begin
            if (w_valid) begin
                w_next_state = f_enc(w_cur_dir, C_PH_YEL);
            end
        end else if (w_is_yel) begin
            if (w_valid) begin
                w_next_state = ST_ALL_RED;
                w_next_ptr   = w_cur_dir + 2'd1;
            end
        end else begin
            // Unused code: recover to a safe state.
            w_next_state = ST_ALL_RED;
        end
        // A new state, or an active emergency, makes the next cycle a guard cycle.
        w_next_guard = emergency || (w_next_state != r_state);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_ALL_RED;
            r_lights <= C_ALL_RED_LT;
            r_ptr    <= C_FIRST_DIR;
            r_guard  <= 1'b1;
        end else begin
            r_state  <= w_next_state;
            r_lights <= f_lights(w_next_state);
            r_ptr    <= w_next_ptr;
            r_guard  <= w_next_guard;
        end
    end

    assign state  = r_state;
    assign lights = r_lights;

endmodule
`default_nettype wire

// File: tb/tb_traffic_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_traffic_fsm
// Description : Self-checking bench for traffic_fsm. A reference model
//               tracks (phase, direction, pointer, guard). The bench compares
//               its state and lights with the DUT on every falling edge. Hand
//               computed sequences pin the main scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_fsm;

    localparam int FIRST_DIR = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        expired;
    logic [3:0]  demand;
    logic [3:0]  congestion;
    logic        emergency;
    logic [3:0]  state;
    logic [11:0] lights;

    int errors = 0;
    int checks = 0;

    traffic_fsm #(.FIRST_DIR(FIRST_DIR)) dut (
        .clk        (clk),
        .rst        (rst),
        .expired    (expired),
        .demand     (demand),
        .congestion (congestion),
        .emergency  (emergency),
        .state      (state),
        .lights     (lights)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 all-red, 1 green, 2 extended green, 3 yellow
    int m_phase;
    int m_dir;
    int m_ptr;
    bit m_guard;

    always @(posedge clk or posedge rst) begin
        int ph, dr, pt, s;
        bit g, found;
        if (rst) begin
            m_phase <= 0;
            m_dir   <= 0;
            m_ptr   <= FIRST_DIR;
            m_guard <= 1'b1;
        end else begin
            ph = m_phase; dr = m_dir; pt = m_ptr; g = 1'b0;
            if (emergency) begin
                if (ph != 0) pt = dr;
                ph = 0;
                g  = 1'b1;
            end else if (expired && !m_guard) begin
                g = 1'b1;
                if (ph == 0) begin
                    s = pt; found = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        if (!found && demand[(pt + k) % 4]) begin
                            s = (pt + k) % 4;
                            found = 1'b1;
                        end
                    end
                    dr = s;
                    ph = congestion[s] ? 2 : 1;
                end else if (ph == 3) begin
                    ph = 0;
                    pt = (dr + 1) % 4;
                end else begin
                    ph = 3;
                end
            end
            m_phase <= ph;
            m_dir   <= dr;
            m_ptr   <= pt;
            m_guard <= g;
        end
    end

    function automatic logic [3:0] model_state();
        return (m_phase == 0) ? 4'd0 : 4'(3 * m_dir + m_phase);
    endfunction

    function automatic logic [11:0] model_lights();
        logic [11:0] lt;
        for (int d = 0; d < 4; d++) begin
            if (m_phase != 0 && m_dir == d)
                lt[3*d +: 3] = (m_phase == 3) ? 3'b010 : 3'b001;
            else
                lt[3*d +: 3] = 3'b100;
        end
        return lt;
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_state", {8'd0, state}, {8'd0, model_state()});
        check("model_lights", lights, model_lights());
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        expired = 1'b0; emergency = 1'b0; demand = 4'd0; congestion = 4'd0;
        tick();
        rst = 1'b0;
    endtask

    // Expired pulse on every third cycle; check each state the DUT enters.
    logic [3:0] seq [12] = '{4'd1, 4'd3, 4'd0, 4'd4, 4'd6, 4'd0,
                             4'd7, 4'd9, 4'd0, 4'd10, 4'd12, 4'd0};

    task automatic run_seq(input string name);
        for (int i = 0; i < 12; i++) begin
            expired = 1'b0;
            tick();
            tick();
            expired = 1'b1;
            tick();
            expired = 1'b0;
            check(name, {8'd0, state}, {8'd0, seq[i]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; expired = 1'b0; demand = 4'd0; congestion = 4'd0; emergency = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", {8'd0, state}, 12'd0);
        check("reset_lights", lights, 12'h924);
        rst = 1'b0;

        // Full rotation with demand everywhere.
        demand = 4'b1111; congestion = 4'b0000;
        run_seq("rotate_all_demand");

        // No demand: every direction is still served in order.
        do_reset();
        run_seq("rotate_no_demand");

        // Congested direction 2 selected from ptr 0.
        do_reset();
        demand = 4'b0100; congestion = 4'b0100;
        tick();
        expired = 1'b1;
        tick();
        expired = 1'b0;
        check("ext_green2_state", {8'd0, state}, 12'd8);
        check("ext_green2_lights", lights, 12'h864);

        // Expired held high: each state lasts guard + expiry cycle.
        do_reset();
        demand = 4'b1111; congestion = 4'b0000;
        expired = 1'b1;
        tick(); check("held_exp_c1", {8'd0, state}, 12'd0);
        tick(); check("held_exp_c2", {8'd0, state}, 12'd1);
        tick(); check("held_exp_c3", {8'd0, state}, 12'd1);
        tick(); check("held_exp_c4", {8'd0, state}, 12'd3);
        tick(); check("held_exp_c5", {8'd0, state}, 12'd3);
        tick(); check("held_exp_c6", {8'd0, state}, 12'd0);
        expired = 1'b0;

        // Emergency in GREEN_1 with simultaneous expiry.
        do_reset();
        demand = 4'b0010;
        tick();
        expired = 1'b1;
        tick();
        expired = 1'b0;
        check("emg_enter_green1", {8'd0, state}, 12'd4);
        tick();
        emergency = 1'b1; expired = 1'b1;
        tick();
        expired = 1'b0;
        check("emg_state", {8'd0, state}, 12'd0);
        check("emg_lights", lights, 12'h924);
        for (int i = 0; i < 5; i++) begin
            expired = (i % 2 == 0);
            tick();
            check("emg_hold", {8'd0, state}, 12'd0);
        end
        emergency = 1'b0; demand = 4'b0000; expired = 1'b1;
        tick();
        check("emg_release_guard", {8'd0, state}, 12'd0);
        tick();
        check("emg_reserve_dir1", {8'd0, state}, 12'd4);
        expired = 1'b0;

        // Asynchronous reset during YELLOW_3.
        do_reset();
        demand = 4'b1000;
        tick();
        expired = 1'b1;
        tick();
        expired = 1'b0;
        check("yel3_green3", {8'd0, state}, 12'd10);
        tick();
        expired = 1'b1;
        tick();
        expired = 1'b0;
        check("yel3_enter", {8'd0, state}, 12'd12);
        #1 rst = 1'b1;
        #1;
        check("async_rst_state", {8'd0, state}, 12'd0);
        check("async_rst_lights", lights, 12'h924);
        @(posedge clk);
        #2 rst = 1'b0;
        demand = 4'b1111;
        tick();
        expired = 1'b1;
        tick();
        expired = 1'b0;
        check("after_rst_first_dir", {8'd0, state}, 12'd1);

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            demand     = 4'($urandom);
            congestion = 4'($urandom);
            expired    = ($urandom % 3) != 0;
            emergency  = ($urandom % 20) == 0;
            tick();
            if (($urandom % 150) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        emergency = 1'b0; expired = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
